fetch_exec_unit: RTL and testbench



---
 rtl/fetch_exec_unit.sv | 84 ++++++++
 tb/tb_fetch_exec_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_exec_unit.sv
// fetch_exec_unit: PC controller, synchronous-read instruction memory and combinational ALU
module fetch_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               take_branch,
    input  logic               is_relative_branch,
    input  logic [WIDTH-1:0]   branch_addr,
    output logic [WIDTH-1:0]   pc_out,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [WIDTH-1:0]   imem_wdata,
    output logic [WIDTH-1:0]   inst,
    input  logic [4:0]         opcode,
    input  logic [2:0]         cc,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic [WIDTH-1:0]   data_z
);
    logic [WIDTH-1:0] mem [0:(2**IMEM_AW)-1];
    logic             cond;

    // PC: hold, step by one word, or branch relative/absolute; wraps silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_out <= '0;
        else if (enable)
            pc_out <= take_branch ? (is_relative_branch ? pc_out + branch_addr : branch_addr)
                                  : pc_out + 1'b1;
    end

    // fetch register: captures the word at the pre-edge PC; upper PC bits alias
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            inst <= '0;
        else
            inst <= mem[pc_out[IMEM_AW-1:0]];
    end

    // program-load port; kept out of reset so contents survive it, read-first by construction
    always_ff @(posedge clk) begin
        if (imem_we)
            mem[imem_waddr] <= imem_wdata;
    end

    // compare condition: signed codes 2..5, unsigned codes 6..7
    always_comb begin
        cond = 1'b0;
        case (cc)
            3'd0: cond = data_a == data_b;
            3'd1: cond = data_a != data_b;
            3'd2: cond = $signed(data_a) <  $signed(data_b);
            3'd3: cond = $signed(data_a) <= $signed(data_b);
            3'd4: cond = $signed(data_a) >  $signed(data_b);
            3'd5: cond = $signed(data_a) >= $signed(data_b);
            3'd6: cond = data_a <  data_b;
            3'd7: cond = data_a >= data_b;
            default: cond = 1'b0;
        endcase
    end

    // ALU result; unassigned opcodes yield zero
    always_comb begin
        data_z = '0;
        case (opcode)
            5'h00: data_z = data_a;
            5'h01: data_z = data_a + data_b;
            5'h02: data_z = data_a - data_b;
            5'h03: data_z = data_a & data_b;
            5'h04: data_z = data_a | data_b;
            5'h05: data_z = data_a ^ data_b;
            5'h06: data_z = ~data_a;
            5'h07: data_z = data_a << data_b[4:0];
            5'h08: data_z = data_a >> data_b[4:0];
            5'h09: data_z = $signed(data_a) >>> data_b[4:0];
            5'h0A: data_z = {{(WIDTH-1){1'b0}}, cond};
            5'h0B: data_z = data_a;
            default: data_z = '0;
        endcase
    end
endmodule

// File: tb/tb_fetch_exec_unit.sv
// tb_fetch_exec_unit: directed, table-driven and randomized checks against a behavioural model
module tb_fetch_exec_unit;
    logic        clk = 0;
    logic        reset = 0;
    logic        enable = 0;
    logic        take_branch = 0;
    logic        is_relative_branch = 0;
    logic [31:0] branch_addr = 0;
    logic [31:0] pc_out;
    logic        imem_we = 0;
    logic [7:0]  imem_waddr = 0;
    logic [31:0] imem_wdata = 0;
    logic [31:0] inst;
    logic [4:0]  opcode = 0;
    logic [2:0]  cc = 0;
    logic [31:0] data_a = 0;
    logic [31:0] data_b = 0;
    logic [31:0] data_z;

    int passes = 0;
    int total = 0;

    logic [31:0] mem_m [256];
    logic [31:0] pc_m = 0;
    logic [31:0] inst_m = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [2:0]  cc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } alu_vec_t;

    alu_vec_t tbl [20];

    fetch_exec_unit #(.WIDTH(32), .IMEM_AW(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .take_branch(take_branch),
        .is_relative_branch(is_relative_branch), .branch_addr(branch_addr), .pc_out(pc_out),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .inst(inst),
        .opcode(opcode), .cc(cc), .data_a(data_a), .data_b(data_b), .data_z(data_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // one clock edge; the model follows the stated rules using the pre-edge state
    task automatic step();
        @(posedge clk);
        if (reset) begin
            pc_m = 0;
            inst_m = 0;
        end else begin
            inst_m = mem_m[pc_m[7:0]];
            if (enable)
                pc_m = !take_branch ? pc_m + 1 : (is_relative_branch ? pc_m + branch_addr : branch_addr);
        end
        if (imem_we) mem_m[imem_waddr] = imem_wdata;
        #1;
    endtask

    task automatic write_mem(input logic [7:0] addr, input logic [31:0] data);
        imem_we = 1; imem_waddr = addr; imem_wdata = data;
        step();
        imem_we = 0;
    endtask

    task automatic pc_op(input logic en, input logic tb, input logic rel, input logic [31:0] ba);
        enable = en; take_branch = tb; is_relative_branch = rel; branch_addr = ba;
        step();
        enable = 0; take_branch = 0; is_relative_branch = 0;
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1;
        pc_m = 0; inst_m = 0;
        #1;
        check({tag, "_pc"}, pc_out, 32'h0);
        check({tag, "_inst"}, inst, 32'h0);
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [2:0] c,
                                             input logic [31:0] a, input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        longint      p = longint'(1) << b[4:0];
        longint      q;
        longint unsigned prod;
        logic        r;
        case (c)
            0: r = a == b;
            1: r = a != b;
            2: r = sa < sb;
            3: r = sa <= sb;
            4: r = sa > sb;
            5: r = sa >= sb;
            6: r = a < b;
            default: r = a >= b;
        endcase
        case (op)
            0, 11: return a;
            1: return a + b;
            2: return a - b;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: return ~a;
            7: begin prod = longint'(a) * p; return prod[31:0]; end
            8: return 32'(longint'(a) / p);
            9: begin
                q = longint'(sa) / p;
                if (sa < 0 && (longint'(sa) % p) != 0) q = q - 1;
                return 32'(q);
            end
            10: return {31'b0, r};
            default: return 0;
        endcase
    endfunction

    initial begin
        tbl[0]  = '{"add_wrap", 5'h01, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0};
        tbl[1]  = '{"sub_neg",  5'h02, 3'd0, 32'h3, 32'h5, 32'hFFFF_FFFE};
        tbl[2]  = '{"sra",      5'h09, 3'd0, 32'h8000_0000, 32'h4, 32'hF800_0000};
        tbl[3]  = '{"shr",      5'h08, 3'd0, 32'h8000_0000, 32'h4, 32'h0800_0000};
        tbl[4]  = '{"op1f",     5'h1F, 3'd0, 32'h1234_5678, 32'h9, 32'h0};
        tbl[5]  = '{"cmp_lt",   5'h0A, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h1};
        tbl[6]  = '{"cmp_ltu",  5'h0A, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h0};
        tbl[7]  = '{"cmp_geu",  5'h0A, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h1};
        tbl[8]  = '{"cmp_ne",   5'h0A, 3'd1, 32'hFFFF_FFFF, 32'h1, 32'h1};
        tbl[9]  = '{"cmp_eq",   5'h0A, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0};
        tbl[10] = '{"cmp_le",   5'h0A, 3'd3, 32'h7, 32'h7, 32'h1};
        tbl[11] = '{"cmp_ge",   5'h0A, 3'd5, 32'h7, 32'h7, 32'h1};
        tbl[12] = '{"cmp_gt",   5'h0A, 3'd4, 32'h7, 32'h7, 32'h0};
        tbl[13] = '{"mov",      5'h00, 3'd0, 32'hCAFE_F00D, 32'h1, 32'hCAFE_F00D};
        tbl[14] = '{"and",      5'h03, 3'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000};
        tbl[15] = '{"or",       5'h04, 3'd0, 32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF};
        tbl[16] = '{"xor",      5'h05, 3'd0, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
        tbl[17] = '{"not",      5'h06, 3'd0, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000};
        tbl[18] = '{"shl",      5'h07, 3'd0, 32'h0000_0003, 32'h0000_0023, 32'h0000_0018};
        tbl[19] = '{"br",       5'h0B, 3'd0, 32'hFFFF_FFFE, 32'h7, 32'hFFFF_FFFE};

        foreach (mem_m[i]) mem_m[i] = 0;

        // reset state, no clock edge
        #2 reset = 1;
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst, 32'h0);
        reset = 0;

        // clear program memory so its contents are known independently of simulator init
        for (int i = 0; i < 256; i++) write_mem(8'(i), 32'h0);
        write_mem(8'd0, 32'h3800_0010);
        write_mem(8'd4, 32'hDEAD_BEEF);

        // reach pc=5, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) pc_op(1, 0, 0, 0);
        check("pc5", pc_out, 32'h5);
        check("inst_at_pc4", inst, 32'hDEAD_BEEF);
        async_reset_check("async_rst");
        reset = 0;
        step();
        check("first_fetch", inst, 32'h3800_0010);
        check("first_fetch_pc", pc_out, 32'h0);

        // sequential fetch
        write_mem(8'd0, 32'h11);
        write_mem(8'd1, 32'h22);
        write_mem(8'd2, 32'h33);
        write_mem(8'd3, 32'h44);
        step();
        check("seq_inst0", inst, 32'h11);
        for (int k = 1; k <= 3; k++) begin
            pc_op(1, 0, 0, 0);
            check($sformatf("seq_pc%0d", k), pc_out, 32'(k));
            step();
            check($sformatf("seq_inst%0d", k), inst, mem_m[k]);
        end

        // branches
        pc_op(1, 0, 0, 0);
        check("pc4", pc_out, 32'h4);
        pc_op(1, 1, 1, 32'hFFFF_FFFE);
        check("rel_back", pc_out, 32'h2);
        pc_op(1, 1, 0, 32'h10);
        check("abs_branch", pc_out, 32'h10);
        pc_op(0, 1, 0, 32'h55);
        check("no_enable", pc_out, 32'h10);
        pc_op(1, 0, 1, 32'h40);
        check("rel_ignored", pc_out, 32'h11);

        // wrap and fetch aliasing
        pc_op(1, 1, 0, 32'hFFFF_FFFF);
        check("pc_max", pc_out, 32'hFFFF_FFFF);
        pc_op(1, 0, 0, 0);
        check("pc_wrap", pc_out, 32'h0);
        pc_op(1, 1, 0, 32'h100);
        step();
        check("alias_fetch", inst, 32'h11);

        // read-first on same-address write
        pc_op(1, 1, 0, 32'h2);
        step();
        write_mem(8'd2, 32'h0000_ABCD);
        check("rdfirst_old", inst, 32'h33);
        step();
        check("rdfirst_new", inst, 32'h0000_ABCD);

        // randomized PC/memory traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            enable = ($urandom_range(0, 2) == 0);
            take_branch = $urandom_range(0, 1);
            is_relative_branch = $urandom_range(0, 1);
            branch_addr = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 600)) - 32'd300;
            imem_we = !reset && ($urandom_range(0, 1) == 0);
            imem_waddr = 8'($urandom);
            imem_wdata = $urandom;
            step();
            check("rnd_pc", pc_out, pc_m);
            check("rnd_inst", inst, inst_m);
        end
        reset = 0; enable = 0; take_branch = 0; imem_we = 0;

        // ALU table
        foreach (tbl[i]) begin
            opcode = tbl[i].op; cc = tbl[i].cc; data_a = tbl[i].a; data_b = tbl[i].b;
            #1;
            check(tbl[i].name, data_z, tbl[i].z);
        end

        // randomized ALU
        for (int n = 0; n < 300; n++) begin
            opcode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
            cc = 3'($urandom);
            data_a = $urandom;
            data_b = ($urandom_range(0, 3) == 0) ? data_a : $urandom;
            #1;
            check($sformatf("rnd_alu_op%0h_cc%0d", opcode, cc), data_z, alu_ref(opcode, cc, data_a, data_b));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
